// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display page scheduler.
//   state_e     : scheduler pages, encoded so the state value doubles as the page code
//   SegOff      : seven_seg code that blanks a digit
//   SegNegative : seven_seg code that shows a minus sign
//   Page*       : page codes driven on page_o
package disp_sched_pkg;

  typedef enum logic [2:0] {
    StEntry = 3'd0,
    StTemp  = 3'd1,
    StGap1  = 3'd2,
    StDiff  = 3'd3,
    StGap2  = 3'd4
  } state_e;

  localparam logic [3:0] SegOff      = 4'hF;
  localparam logic [3:0] SegNegative = 4'hA;

  localparam logic [2:0] PageEntry = 3'd0;
  localparam logic [2:0] PageTemp  = 3'd1;
  localparam logic [2:0] PageGap1  = 3'd2;
  localparam logic [2:0] PageDiff  = 3'd3;
  localparam logic [2:0] PageGap2  = 3'd4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/disp_sched_blink.sv
// Free-running blink generator. Counts 0..Half-1 and toggles blink_o on each wrap.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (blink_o = 1, counter = 0)
//   blink_o : blink phase, 1 = on
module blink_gen #(
  parameter int unsigned Half = 25000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic blink_o
);

  localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            blink_q, blink_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    blink_d = blink_q;
    if (cnt_q == CntW'(Half - 1)) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink_o = blink_q;

endmodule

// File: rtl/disp_sched.sv
// Display page scheduler for the four 7-segment digits.
// During digit entry it shows the digits entered so far with the active digit blinking;
// once entry completes it rotates TEMP -> GAP1 -> DIFF -> GAP2 -> TEMP.
//   entry_idx_i          : digit being entered (0..2), 3 = entry complete
//   entry_digit_i        : live switch digit
//   sign_on_i            : entered value is negative
//   cur_*_i              : digits already committed during entry
//   temp_*_i, diff_*_i   : current temperature and subtractor result, BCD
//   diff_neg_i           : subtractor result is negative
//   new_value_i          : one-cycle pulse, restarts rotation at TEMP
//   hold_i               : freeze the current rotation page
//   hexN_val_o/hexN_en_o : registered code and enable per seven_seg
//   page_o               : current page, blink_o : blink phase
module disp_sched
  import disp_sched_pkg::*;
#(
  parameter int unsigned DwellCyc  = 50000000,
  parameter int unsigned GapCyc    = 25000000,
  parameter int unsigned BlinkHalf = 25000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] entry_idx_i,
  input  logic [3:0] entry_digit_i,
  input  logic       sign_on_i,
  input  logic [3:0] cur_ones_i,
  input  logic [3:0] cur_tens_i,
  input  logic [3:0] cur_huns_i,
  input  logic [3:0] temp_ones_i,
  input  logic [3:0] temp_tens_i,
  input  logic [3:0] temp_huns_i,
  input  logic [3:0] diff_ones_i,
  input  logic [3:0] diff_tens_i,
  input  logic [3:0] diff_huns_i,
  input  logic       diff_neg_i,
  input  logic       new_value_i,
  input  logic       hold_i,
  output logic [3:0] hex0_val_o,
  output logic [3:0] hex1_val_o,
  output logic [3:0] hex2_val_o,
  output logic [3:0] hex3_val_o,
  output logic       hex0_en_o,
  output logic       hex1_en_o,
  output logic       hex2_en_o,
  output logic       hex3_en_o,
  output logic [2:0] page_o,
  output logic       blink_o
);

  localparam int unsigned CntW = $clog2(max_u(DwellCyc, GapCyc));

  state_e          state_q, state_d;
  logic [CntW-1:0] dwell_q, dwell_d;
  logic [CntW-1:0] dwell_last;
  logic [3:0][3:0] val_q, val_d;
  logic [3:0]      en_q, en_d;
  logic            blink;

  // Huns digit is never shown during entry: entry_idx 2 displays the live digit there.
  logic unused_cur_huns;
  assign unused_cur_huns = ^cur_huns_i;

  blink_gen #(
    .Half (BlinkHalf)
  ) u_blink (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .blink_o (blink)
  );

  assign dwell_last = ((state_q == StTemp) || (state_q == StDiff)) ?
                      CntW'(DwellCyc - 1) : CntW'(GapCyc - 1);

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (entry_idx_i != 3'd3) begin
      state_d = StEntry;
      dwell_d = '0;
    end else if (state_q == StEntry || new_value_i) begin
      state_d = StTemp;
      dwell_d = '0;
    end else if (!hold_i) begin
      if (dwell_q == dwell_last) begin
        dwell_d = '0;
        unique case (state_q)
          StTemp:  state_d = StGap1;
          StGap1:  state_d = StDiff;
          StDiff:  state_d = StGap2;
          StGap2:  state_d = StTemp;
          default: state_d = StEntry;
        endcase
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so the digits line up with page_o.
  always_comb begin
    val_d = {4{SegOff}};
    en_d  = 4'hF;
    unique case (state_d)
      StEntry: begin
        val_d[3] = sign_on_i ? SegNegative : SegOff;
        case (entry_idx_i)
          3'd0: val_d[0] = entry_digit_i;
          3'd1: begin
            val_d[0] = cur_ones_i;
            val_d[1] = entry_digit_i;
          end
          3'd2: begin
            val_d[0] = cur_ones_i;
            val_d[1] = cur_tens_i;
            val_d[2] = entry_digit_i;
          end
          default: ;
        endcase
        if (entry_idx_i != 3'd3) en_d[entry_idx_i[1:0]] = blink;
      end
      StTemp: begin
        val_d = {(sign_on_i ? SegNegative : SegOff), temp_huns_i, temp_tens_i, temp_ones_i};
      end
      StDiff: begin
        val_d = {(diff_neg_i ? SegNegative : SegOff), diff_huns_i, diff_tens_i, diff_ones_i};
      end
      StGap1, StGap2: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEntry;
      dwell_q <= '0;
      val_q   <= {4{SegOff}};
      en_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      val_q   <= val_d;
      en_q    <= en_d;
    end
  end

  assign hex0_val_o = val_q[0];
  assign hex1_val_o = val_q[1];
  assign hex2_val_o = val_q[2];
  assign hex3_val_o = val_q[3];
  assign hex0_en_o  = en_q[0];
  assign hex1_en_o  = en_q[1];
  assign hex2_en_o  = en_q[2];
  assign hex3_en_o  = en_q[3];
  assign page_o     = state_q;
  assign blink_o    = blink;

endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
Display page scheduler for the temperature monitor's four 7-segment digits. Selects what each digit shows in two situations:
- Digit entry: shows the digits entered so far, with the digit being entered blinking.
- After entry: rotates through current-temperature and difference pages, with blank gaps between them.
Sits between bcd_in/bcd_subtractor outputs and the four seven_seg instances. Replaces the free-running display-state mux in top.

Parameters:
DWELL_CYC, 50000000, clk cycles each value page (TEMP, DIFF) is shown; must be >= 2
GAP_CYC, 25000000, clk cycles each blank gap page is shown; must be >= 1
BLINK_HALF, 25000000, clk cycles per blink half-period; must be >= 1

Ports:
clk  input  1  system clock (CLOCK_50)
rst  input  1  asynchronous, active-low reset
entry_idx  input  3  digit currently being entered: 0 ones, 1 tens, 2 huns, 3 entry complete (bcd_press)
entry_digit  input  4  live switch digit being entered
sign_on  input  1  entered value is negative
cur_ones/cur_tens/cur_huns  input  4 each  digits already committed during entry
temp_ones/temp_tens/temp_huns  input  4 each  current temperature, BCD
diff_ones/diff_tens/diff_huns  input  4 each  subtractor result, BCD
diff_neg  input  1  subtractor result is negative
new_value  input  1  one-cycle pulse: new temperature accepted (got_value)
hold  input  1  freeze the current rotation page
hex0_val..hex3_val  output  4 each  code sent to each seven_seg
hex0_en..hex3_en  output  1 each  seven_seg enable (0 = digit dark)
page  output  3  current page: 0 ENTRY, 1 TEMP, 2 GAP1, 3 DIFF, 4 GAP2
blink  output  1  blink phase (1 = on)

Behaviour:
Reset (rst=0, asynchronous):
- state ENTRY; dwell and blink counters 0
- blink=1; page=0
- all hexN_val=`OFF; all hexN_en=1
- Takes effect mid-rotation or mid-entry, with no delay.

Blink generator:
- Counts 0..BLINK_HALF-1 continuously.
- blink toggles on each wrap.
- Runs in every state and is unaffected by hold.

FSM states: ENTRY, TEMP, GAP1, DIFF, GAP2.
Transition priority per cycle, highest first:
1. entry_idx != 3 -> ENTRY (from any state); dwell counter cleared.
2. ENTRY and entry_idx == 3 -> TEMP; dwell counter cleared.
3. new_value=1 while rotating -> TEMP; dwell counter cleared. Applies even if already in TEMP (restarts the dwell).
4. hold=1 -> stay in the current state; dwell counter frozen.
5. Dwell expiry. Each page lasts exactly its count:
   - TEMP -> GAP1 when the counter reaches DWELL_CYC-1
   - GAP1 -> DIFF when the counter reaches GAP_CYC-1
   - DIFF -> GAP2 when the counter reaches DWELL_CYC-1
   - GAP2 -> TEMP when the counter reaches GAP_CYC-1
   - Counter clears on every state change.

Outputs:
- All outputs are registered: one clk of latency from a state or input change.
- ENTRY mapping (hex3 = sign_on ? `NEGATIVE : `OFF in all three cases):
  - entry_idx=0: hex0=entry_digit; hex1=`OFF; hex2=`OFF
  - entry_idx=1: hex0=cur_ones; hex1=entry_digit; hex2=`OFF
  - entry_idx=2: hex0=cur_ones; hex1=cur_tens; hex2=entry_digit
  - hexN_en: the digit at index entry_idx gets en=blink; all other digits en=1
- TEMP: hex0..2=temp_ones/tens/huns; hex3 = sign_on ? `NEGATIVE : `OFF; all en=1
- DIFF: hex0..2=diff_ones/tens/huns; hex3 = diff_neg ? `NEGATIVE : `OFF; all en=1
- GAP1/GAP2: all hex=`OFF; all en=1
- page reflects the registered state.

Other rules:
- Value inputs are sampled live every cycle; there is no latching in the scheduler.
- Counter widths come from $clog2 of the largest parameter; no wrap occurs before terminal count.

Decomposition:
- Existing constants.vh already provides `OFF and `NEGATIVE.
- Add to constants.vh: `PAGE_ENTRY=0, `PAGE_TEMP=1, `PAGE_GAP1=2, `PAGE_DIFF=3, `PAGE_GAP2=4.
- One sub-module: blink_gen (parameter HALF; ports clk, rst, blink). Reusable by the LED blink in top.

Test Plan (DWELL_CYC=8, GAP_CYC=2, BLINK_HALF=3):
1. Reset, then entry_idx=0, entry_digit=7, sign_on=1 -> page=0; hex0_val=7; hex1_val=hex2_val=`OFF; hex3_val=`NEGATIVE; hex0_en toggles every 3 cycles; hex1/2/3_en=1.
2. entry_idx=2, cur_ones=5, cur_tens=2, entry_digit=1 -> hex0=5, hex1=2, hex2=1; only hex2_en blinks.
3. entry_idx -> 3 with temp=0,4,2 (huns,tens,ones), diff=0,1,3, diff_neg=1 -> page sequence TEMP x8, GAP1 x2, DIFF x8, GAP2 x2, TEMP. DIFF page shows hex3=`NEGATIVE, hex1=1, hex0=3. GAP pages show all `OFF.
4. new_value pulse on cycle 4 of DIFF -> TEMP on the next cycle, then 8 full TEMP cycles. new_value on cycle 5 of TEMP -> TEMP dwell restarts (13 TEMP cycles total).
5. hold=1 for 20 cycles on cycle 3 of TEMP -> page stays 1 throughout and blink keeps toggling. After release, 5 more TEMP cycles, then GAP1.
6. rst low mid-DIFF -> immediately page=0, all hex=`OFF, all en=1, blink=1. entry_idx=1 during rotation -> ENTRY next cycle, with hex1_en blinking.
